// File: rtl/bw_io_impctl_pkg.sv
// Shared types and default constants for the impedance-control calibration engine.
//   state_e : calibration FSM states
//   dir_e   : search direction of the last non-tie decision
package bw_io_impctl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSample,
    StAdjust,
    StLocked
  } state_e;

  typedef enum logic [1:0] {
    DirNone,
    DirUp,
    DirDown
  } dir_e;

  localparam int unsigned CodeWDef       = 6;
  localparam int unsigned CodeInitDef    = 32;
  localparam int unsigned SettleCycDef   = 16;
  localparam int unsigned FiltNDef       = 8;
  localparam int unsigned LockCntDef     = 3;
  localparam int unsigned TrackPeriodDef = 1024;

endpackage

// File: rtl/bw_io_impctl_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk   : destination clock
//   reset : asynchronous active-high reset (output clears to 0)
//   d_i   : asynchronous input
//   q_o   : synchronized output, two cycles of latency
module bw_io_impctl_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bw_io_impctl_cal.sv
// Impedance-control calibration engine. Runs a filtered up/down search on imp_code
// until the comparator decision reverses LOCK_CNT times, then publishes the code.
//   clk, reset   : core clock, asynchronous active-high reset
//   vref_impctl  : reference valid; low aborts or blocks calibration
//   cmp_hi       : asynchronous comparator, 1 = code must increase
//   cal_start    : single-cycle start request (accepted in IDLE or LOCKED)
//   imp_code     : current impedance code
//   code_upd     : one-cycle pulse alongside each new imp_code value
//   cal_busy     : search in progress
//   cal_done     : locked, imp_code valid
//   cal_sat      : search ran into code 0 or max
// Build option BW_IO_IMPCTL_TRACK_EN: periodic re-check while LOCKED.
module bw_io_impctl_cal
  import bw_io_impctl_pkg::*;
#(
  parameter int unsigned CODE_W       = CodeWDef,
  parameter int unsigned CODE_INIT    = CodeInitDef,
  parameter int unsigned SETTLE_CYC   = SettleCycDef,
  parameter int unsigned FILT_N       = FiltNDef,
  parameter int unsigned LOCK_CNT     = LockCntDef,
  parameter int unsigned TRACK_PERIOD = TrackPeriodDef
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vref_impctl,
  input  logic              cmp_hi,
  input  logic              cal_start,
  output logic [CODE_W-1:0] imp_code,
  output logic              code_upd,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_sat
);

  localparam int unsigned SettleW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned SampW   = $clog2(FILT_N + 1);
  localparam int unsigned RevW    = $clog2(LOCK_CNT + 1);

  localparam logic [CODE_W-1:0]  CodeInit   = CODE_W'(CODE_INIT);
  localparam logic [CODE_W-1:0]  CodeMax    = '1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYC - 1);
  localparam logic [SampW-1:0]   SampLast   = SampW'(FILT_N - 1);
  localparam logic [SampW-1:0]   Half       = SampW'(FILT_N / 2);
  localparam logic [RevW-1:0]    RevMax     = RevW'(LOCK_CNT);

  if (SETTLE_CYC < 1 || FILT_N < 2 || (FILT_N & (FILT_N - 1)) != 0 || LOCK_CNT < 1 ||
      TRACK_PERIOD < 1) begin : g_param_check
    $error("bw_io_impctl_cal: illegal parameter value");
  end

  state_e              state_q, state_d;
  dir_e                last_dir_q, last_dir_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                upd_q, upd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sat_q, sat_d;
  logic [SettleW-1:0]  settle_cnt_q, settle_cnt_d;
  logic [SampW-1:0]    samp_cnt_q, samp_cnt_d;
  logic [SampW-1:0]    ones_q, ones_d;
  logic [RevW-1:0]     rev_cnt_q, rev_cnt_d;
  logic [RevW-1:0]     rev_inc, rev_next;
  logic                cmp_sync;
  logic                dec_tie;
  dir_e                dec_dir;
  logic                at_limit;
  logic [CODE_W-1:0]   code_step;

`ifdef BW_IO_IMPCTL_TRACK_EN
  localparam int unsigned PeriodW = $clog2(TRACK_PERIOD + 1);
  localparam logic [PeriodW-1:0] PeriodLast = PeriodW'(TRACK_PERIOD - 1);
  logic               track_q, track_d;  // set while a re-check pass runs out of LOCKED
  logic [PeriodW-1:0] period_cnt_q, period_cnt_d;
`endif

  bw_io_impctl_sync2 u_cmp_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (cmp_hi),
    .q_o   (cmp_sync)
  );

  assign rev_inc   = (rev_cnt_q == RevMax) ? rev_cnt_q : rev_cnt_q + RevW'(1);
  assign dec_tie   = (ones_q == Half);
  assign dec_dir   = (ones_q > Half) ? DirUp : DirDown;
  assign at_limit  = (dec_dir == DirUp) ? (code_q == CodeMax) : (code_q == '0);
  assign code_step = (dec_dir == DirUp) ? code_q + CODE_W'(1) : code_q - CODE_W'(1);

  always_comb begin
    state_d      = state_q;
    last_dir_d   = last_dir_q;
    code_d       = code_q;
    busy_d       = busy_q;
    done_d       = done_q;
    sat_d        = sat_q;
    settle_cnt_d = '0;
    samp_cnt_d   = '0;
    ones_d       = '0;
    rev_cnt_d    = rev_cnt_q;
    rev_next     = rev_cnt_q;
`ifdef BW_IO_IMPCTL_TRACK_EN
    track_d      = track_q;
    period_cnt_d = '0;
`endif
    if (state_q != StIdle && !vref_impctl) begin
      // Abort: code is held, so no update pulse follows.
      state_d = StIdle;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef BW_IO_IMPCTL_TRACK_EN
      track_d = 1'b0;
`endif
    end else if (cal_start && vref_impctl && (state_q == StIdle || state_q == StLocked)) begin
      state_d    = StSettle;
      code_d     = CodeInit;
      rev_cnt_d  = '0;
      last_dir_d = DirNone;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      sat_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StSettle: begin
          if (settle_cnt_q == SettleLast) begin
            state_d = StSample;
`ifdef BW_IO_IMPCTL_TRACK_EN
            if (track_q) begin
              state_d = StLocked;
              track_d = 1'b0;
            end
`endif
          end else begin
            settle_cnt_d = settle_cnt_q + SettleW'(1);
          end
        end
        StSample: begin
          ones_d = ones_q + SampW'(cmp_sync);
          if (samp_cnt_q == SampLast) begin
            state_d = StAdjust;
          end else begin
            samp_cnt_d = samp_cnt_q + SampW'(1);
          end
        end
        StAdjust: begin
`ifdef BW_IO_IMPCTL_TRACK_EN
          if (track_q) begin
            // Re-check: step only against the dither direction recorded at lock.
            state_d = StLocked;
            track_d = 1'b0;
            if (!dec_tie && last_dir_q != DirNone && dec_dir != last_dir_q) begin
              if (at_limit) begin
                sat_d = 1'b1;
              end else begin
                code_d  = code_step;
                state_d = StSettle;
                track_d = 1'b1;
              end
            end
          end else begin
`endif
          if (dec_tie) begin
            rev_next = rev_inc;
            state_d  = StSample;
          end else begin
            if (last_dir_q != DirNone && dec_dir != last_dir_q) begin
              rev_next = rev_inc;
            end
            last_dir_d = dec_dir;
            if (rev_next != RevMax) begin
              if (at_limit) begin
                sat_d   = 1'b1;
                state_d = StLocked;
              end else begin
                code_d  = code_step;
                state_d = StSettle;
              end
            end
          end
          rev_cnt_d = rev_next;
          if (rev_next == RevMax) begin
            state_d = StLocked;
          end
          if (state_d == StLocked) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
`ifdef BW_IO_IMPCTL_TRACK_EN
          end
`endif
        end
        StLocked: begin
`ifdef BW_IO_IMPCTL_TRACK_EN
          if (period_cnt_q == PeriodLast) begin
            state_d = StSample;
            track_d = 1'b1;
          end else begin
            period_cnt_d = period_cnt_q + PeriodW'(1);
          end
`endif
        end
      endcase
    end
    upd_d = (code_d != code_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_dir_q   <= DirNone;
      code_q       <= CodeInit;
      upd_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sat_q        <= 1'b0;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
      ones_q       <= '0;
      rev_cnt_q    <= '0;
`ifdef BW_IO_IMPCTL_TRACK_EN
      track_q      <= 1'b0;
      period_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_dir_q   <= last_dir_d;
      code_q       <= code_d;
      upd_q        <= upd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sat_q        <= sat_d;
      settle_cnt_q <= settle_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      ones_q       <= ones_d;
      rev_cnt_q    <= rev_cnt_d;
`ifdef BW_IO_IMPCTL_TRACK_EN
      track_q      <= track_d;
      period_cnt_q <= period_cnt_d;
`endif
    end
  end

  assign imp_code = code_q;
  assign code_upd = upd_q;
  assign cal_busy = busy_q;
  assign cal_done = done_q;
  assign cal_sat  = sat_q;

endmodule

// File: tb/tb_bw_io_impctl_cal.sv
// Self-checking bench for bw_io_impctl_cal. Expected codes are queued as each search is
// launched and compared whenever code_upd pulses; step spacing is checked against
// SETTLE_CYC + FILT_N + 1. Tracking scenario runs only with BW_IO_IMPCTL_TRACK_EN.
module tb_bw_io_impctl_cal;

  localparam int unsigned StepGap = 16 + 8 + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vref_impctl = 1'b0;
  logic       cmp_hi = 1'b0;
  logic       cal_start = 1'b0;
  logic [5:0] imp_code;
  logic       code_upd;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_sat;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned sb[$];
  int          cyc = 0;
  int          prev_upd_cyc = 0;
  bit          prev_upd_valid = 1'b0;
  bit          gap_on = 1'b0;
  int          cmp_mode = 0;  // 0: constant, 1: trip point, 2: toggle
  logic        cmp_const = 1'b0;
  int unsigned trip = 40;

  bw_io_impctl_cal dut (
    .clk         (clk),
    .reset       (reset),
    .vref_impctl (vref_impctl),
    .cmp_hi      (cmp_hi),
    .cal_start   (cal_start),
    .imp_code    (imp_code),
    .code_upd    (code_upd),
    .cal_busy    (cal_busy),
    .cal_done    (cal_done),
    .cal_sat     (cal_sat)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_range(input int unsigned lo, input int unsigned hi);
    for (int unsigned c = lo; c <= hi; c++) sb.push_back(c);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
  endtask

  task automatic wait_code(input string tag, input int unsigned code, input int budget);
    for (int i = 0; i < budget && imp_code != code; i++) @(negedge clk);
    check_val(tag, imp_code, code);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !cal_done; i++) @(negedge clk);
    check_val(tag, cal_done, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Comparator model, updated away from the active edge.
  initial forever begin
    @(negedge clk);
    case (cmp_mode)
      1:       cmp_hi = (imp_code < trip);
      2:       cmp_hi = ~cmp_hi;
      default: cmp_hi = cmp_const;
    endcase
  end

  // Scoreboard monitor: every code_upd must match the next queued code.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset && code_upd) begin
      check_val("upd_code", imp_code, (sb.size() != 0) ? sb.pop_front() : 999);
      if (gap_on && prev_upd_valid) check_val("step_gap", cyc - prev_upd_cyc, StepGap);
      prev_upd_cyc   = cyc;
      prev_upd_valid = 1'b1;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check_val("rst_code", imp_code, 32);
    check_val("rst_upd", code_upd, 0);
    check_val("rst_busy", cal_busy, 0);
    check_val("rst_done", cal_done, 0);
    check_val("rst_sat", cal_sat, 0);
    reset = 1'b0;

    // Saturating ramp to max code.
    vref_impctl = 1'b1;
    cmp_mode = 0;
    cmp_const = 1'b1;
    gap_on = 1'b1;
    push_range(33, 63);
    pulse_start();
    check_val("t1_busy", cal_busy, 1);
    wait_done("t1_done", 1000);
    check_val("t1_code", imp_code, 63);
    check_val("t1_sat", cal_sat, 1);
    check_val("t1_busy_end", cal_busy, 0);
    check_val("t1_sb", sb.size(), 0);

    // Dither around trip point 40, restarted from LOCKED.
    cmp_mode = 1;
    trip = 40;
    prev_upd_valid = 1'b0;
    sb.push_back(32);
    push_range(33, 40);
    sb.push_back(39);
    sb.push_back(40);
    pulse_start();
    check_val("t2_done_drop", cal_done, 0);
    wait_done("t2_done", 1000);
    check_val("t2_code", imp_code, 40);
    check_val("t2_busy", cal_busy, 0);
    check_val("t2_sat", cal_sat, 0);
    check_val("t2_sb", sb.size(), 0);

    // vref drop mid-search at 36, then restart.
    cmp_mode = 0;
    prev_upd_valid = 1'b0;
    sb.push_back(32);
    push_range(33, 36);
    pulse_start();
    wait_code("t3_reach36", 36, 300);
    idle(5);
    vref_impctl = 1'b0;
    @(negedge clk);
    check_val("t3_busy", cal_busy, 0);
    check_val("t3_done", cal_done, 0);
    idle(10);
    check_val("t3_hold", imp_code, 36);
    vref_impctl = 1'b1;
    prev_upd_valid = 1'b0;
    sb.push_back(32);
    push_range(33, 45);
    pulse_start();
    check_val("t3_restart", imp_code, 32);
    check_val("t3_rebusy", cal_busy, 1);

    // cal_start while busy is ignored; reset in SAMPLE at 45.
    wait_code("t5_reach44", 44, 400);
    idle(5);
    pulse_start();
    check_val("t5_ign_busy", cal_busy, 1);
    wait_code("t5_reach45", 45, 100);
    check_val("t5_sb", sb.size(), 0);
    idle(20);
    reset = 1'b1;
    #1;
    check_val("t5_rst_code", imp_code, 32);
    check_val("t5_rst_busy", cal_busy, 0);
    check_val("t5_rst_done", cal_done, 0);
    check_val("t5_rst_sat", cal_sat, 0);
    check_val("t5_rst_upd", code_upd, 0);
    sb.delete();
    prev_upd_valid = 1'b0;
    idle(2);
    reset = 1'b0;

    // Toggling comparator: ties only, lock at initial code.
    gap_on = 1'b0;
    cmp_mode = 2;
    pulse_start();
    wait_done("t4_done", 200);
    check_val("t4_code", imp_code, 32);
    check_val("t4_sat", cal_sat, 0);
    check_val("t4_busy", cal_busy, 0);

    // vref low in LOCKED, and cal_start with vref low is dropped.
    vref_impctl = 1'b0;
    @(negedge clk);
    check_val("vlow_done", cal_done, 0);
    pulse_start();
    idle(2);
    check_val("vlow_nostart", cal_busy, 0);

`ifdef BW_IO_IMPCTL_TRACK_EN
    // Tracking: lock at 40, move trip to 42, expect re-check steps with done held.
    vref_impctl = 1'b1;
    cmp_mode = 1;
    trip = 40;
    push_range(33, 40);
    sb.push_back(39);
    sb.push_back(40);
    pulse_start();
    wait_done("t6_lock", 1000);
    check_val("t6_lock_code", imp_code, 40);
    trip = 42;
    push_range(41, 42);
    wait_code("t6_track", 42, 2600);
    check_val("t6_done", cal_done, 1);
    check_val("t6_busy", cal_busy, 0);
    idle(1100);
    check_val("t6_stay", imp_code, 42);
    check_val("t6_sb", sb.size(), 0);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
